// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a downstream 4:1 mux.
// One grant at a time, released on done, on request drop, or after TIMEOUT cycles.
module mux_sel_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pick_valid_c;
  logic [SEL_W-1:0]   pick_idx_c;
  logic [SEL_W-1:0]   scan_idx_c;
  logic               rel_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan from the far end so the requester closest to ptr is the one left standing
  always_comb begin
    pick_valid_c = 1'b0;
    pick_idx_c   = '0;
    scan_idx_c   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      scan_idx_c = ptr_q + SEL_W'(i);
      if (req[scan_idx_c]) begin
        pick_valid_c = 1'b1;
        pick_idx_c   = scan_idx_c;
      end
    end
  end

  assign rel_c = done | ~req[sel_q] | (cnt_q == CNT_MAX);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid_c) state_d = ST_GRANT;
      ST_GRANT: if (rel_c)        state_d = ST_IDLE;
    endcase
  end

  // Registered output and bookkeeping updates
  always_comb begin
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (pick_valid_c) begin
          sel_d   = pick_idx_c;
          grant_d = N_SRC'(1) << pick_idx_c;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (rel_c) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios plus random traffic against
// a cycle-level behavioural model of the arbitration rules.
module tb_mux_sel_arbiter;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: plain integers
  int m_busy, m_sel, m_ptr, m_held;

  mux_sel_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .sel   (sel),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int idx;
    if (m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (r[idx] && m_busy == 0) begin
          m_busy = 1; m_sel = idx; m_held = 1;
        end
      end
    end else if (d || !r[m_sel] || m_held == int'(TO)) begin
      m_busy = 0; m_ptr = (m_sel + 1) % 4; m_held = 0;
    end else if (m_held < int'(TO)) begin
      m_held++;
    end
  endtask

  function automatic logic [3:0] m_grant();
    return (m_busy != 0) ? 4'(1 << m_sel) : 4'b0000;
  endfunction

  // Drive one cycle of inputs, advance model, leave time at posedge+1
  task automatic step(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; done = 1'b0; rst_n = 1'b0;
    #3;
    vectors++;
    if ({sel, grant, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: sel=%0d grant=%b busy=%b required 0/0000/0", sel, grant, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b0000, 1'b1);
    vectors++;
    if ({sel, grant, busy} !== 7'b0) begin
      errors++;
      $display("FAIL done_in_idle: sel=%0d grant=%b busy=%b required 0/0000/0", sel, grant, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0100, 1'b0);
    vectors++;
    if ({sel, grant, busy} !== {2'd2, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL single_grant: sel=%0d grant=%b busy=%b required 2/0100/1", sel, grant, busy);
    end
    step(4'b0100, 1'b1);
    vectors++;
    if ({sel, grant, busy} !== {2'd2, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL single_release: sel=%0d grant=%b busy=%b required 2/0000/0", sel, grant, busy);
    end
    // ptr is now 3, so a full request set picks source 3
    step(4'b1111, 1'b0);
    vectors++;
    if (grant !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL single_ptr3: sel=%0d grant=%b required 3/1000", sel, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      vectors++;
      if (grant !== exp_seq[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant[%0d]: grant=%b busy=%b required %b/1", i, grant, busy, exp_seq[i]);
      end
      step(4'b1111, 1'b1);
      vectors++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle[%0d]: grant=%b busy=%b required 0000/0", i, grant, busy);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    step(4'b1001, 1'b0);
    vectors++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL ptr_wrap: sel=%0d grant=%b required 0/0001", sel, grant);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_pat [7];
    exp_pat = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(4'b0010, 1'b0);
      vectors++;
      if (grant !== exp_pat[i] || sel !== 2'd1) begin
        errors++;
        $display("FAIL timeout[%0d]: sel=%0d grant=%b required 1/%b", i, sel, grant, exp_pat[i]);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    vectors++;
    if ({sel, grant, busy} !== {2'd1, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL req_drop: sel=%0d grant=%b busy=%b required 1/0000/0", sel, grant, busy);
    end
  endtask

  task automatic test_ignore_new();
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    vectors++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL ignore_new: sel=%0d grant=%b required 0/0001", sel, grant);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sel, grant, busy} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: sel=%0d grant=%b busy=%b required 0/0000/0", sel, grant, busy);
    end
    model_reset();
    req = '0; done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    vectors++;
    if (grant !== 4'b0001 || sel !== 2'd0) begin
      errors++;
      $display("FAIL ptr_after_reset: sel=%0d grant=%b required 0/0001", sel, grant);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       d;
    do_reset();
    r = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0);
      step(r, d);
      vectors++;
      if (grant !== m_grant() || busy !== 1'(m_busy) || sel !== 2'(m_sel)) begin
        errors++;
        $display("FAIL random[%0d]: sel=%0d grant=%b busy=%b required %0d/%b/%0d",
                 n, sel, grant, busy, m_sel, m_grant(), m_busy);
      end
      vectors++;
      if (!$onehot0(grant) || (busy && grant !== 4'(1 << sel)) || (!busy && grant !== 4'b0)) begin
        errors++;
        $display("FAIL invariant[%0d]: sel=%0d grant=%b busy=%b", n, sel, grant, busy);
      end
    end
  endtask

  initial begin
    req = '0; done = 1'b0; rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_req_drop();
    test_ignore_new();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
